// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: funct3 widths, FSM states, completion codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_t;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Single-outstanding reqValid/respValid memory bus; master issues one request pulse, slave answers with one response pulse.
interface lsu_mem_master_if #(parameter int XLEN = 32);
  logic            reqValid;
  logic            wen;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wbmask;
  logic [XLEN-1:0] addr;
  logic            respValid;
  logic [XLEN-1:0] rdata;

  modport master (output reqValid, wen, wdata, wbmask, addr, input respValid, rdata);
  modport slave  (input reqValid, wen, wdata, wbmask, addr, output respValid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32 loads/stores: mask, replicated store data, shifted/extended load data, legality flags.
// Purely combinational, zero latency, no backpressure.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wbmask,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] ldata,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] sh;

  always_comb begin
    illegal = wen ? (funct3 > F3_W)
                  : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    // funct3[1:0] carries the access size for both signed and unsigned loads
    misaligned = ((funct3[1:0] == 2'd1) && offset[0]) ||
                 ((funct3[1:0] == 2'd2) && (offset != 2'd0));
  end

  always_comb begin
    wbmask    = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'd0: begin
        wbmask    = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'd1: begin
        wbmask    = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh    = rdata >> {offset, 3'b000};
    ldata = rdata;
    case (funct3)
      F3_B:    ldata = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_BU:   ldata = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_H:    ldata = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_HU:   ldata = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// CPU load/store to single-outstanding memory master; accept->request 1 cycle, response->done 1 cycle.
// cpu_ready only in IDLE; one access in flight; fatal timeout parks in ERR until reset.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_wen,
  input  logic [2:0]       cpu_funct3,
  input  logic [XLEN-1:0]  cpu_addr,
  input  logic [XLEN-1:0]  cpu_wdata,
  output logic             cpu_done,
  output logic [XLEN-1:0]  cpu_rdata,
  output logic [1:0]       cpu_err,
  lsu_mem_master_if.master mem
);

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_nxt;
  logic            done_q, done_nxt;
  err_t            err_q, err_nxt;
  logic [XLEN-1:0] rdata_q, rdata_nxt;
  logic            reqv_q, reqv_nxt;
  logic            wen_q, wen_nxt;
  logic [XLEN-1:0] wdata_q, wdata_nxt;
  logic [3:0]      mask_q, mask_nxt;
  logic [XLEN-1:0] addr_q, addr_nxt;
  logic [31:0]     cnt_q, cnt_nxt;
  logic [1:0]      off_q, off_nxt;
  logic [2:0]      f3_q, f3_nxt;

  logic            idle;
  logic [2:0]      al_funct3;
  logic [1:0]      al_offset;
  logic            al_wen;
  logic [3:0]      al_wbmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_misaligned;
  logic            al_illegal;

  assign idle = (state_q == IDLE);

  // Decode from the live CPU fields at accept time, from latched fields while waiting for data.
  assign al_funct3 = idle ? cpu_funct3 : f3_q;
  assign al_offset = idle ? cpu_addr[1:0] : off_q;
  assign al_wen    = idle ? cpu_wen : wen_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .offset     (al_offset),
    .wen        (al_wen),
    .wdata      (cpu_wdata),
    .rdata      (mem.rdata),
    .wbmask     (al_wbmask),
    .wdata_rep  (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    err_nxt   = ERR_OK;
    rdata_nxt = '0;
    reqv_nxt  = 1'b0;
    wen_nxt   = wen_q;
    wdata_nxt = wdata_q;
    mask_nxt  = mask_q;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    off_nxt   = off_q;
    f3_nxt    = f3_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (al_illegal) begin
            done_nxt = 1'b1;
            err_nxt  = ERR_ILLEGAL;
          end else if (al_misaligned) begin
            done_nxt = 1'b1;
            err_nxt  = ERR_MISALIGN;
          end else begin
            off_nxt   = cpu_addr[1:0];
            f3_nxt    = cpu_funct3;
            wen_nxt   = cpu_wen;
            addr_nxt  = {cpu_addr[XLEN-1:2], 2'b00};
            wdata_nxt = al_wdata;
            mask_nxt  = al_wbmask;
            reqv_nxt  = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem.respValid) begin
          done_nxt  = 1'b1;
          rdata_nxt = wen_q ? '0 : al_ldata;
          state_nxt = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CNT_LAST) begin
            done_nxt  = 1'b1;
            err_nxt   = ERR_TIMEOUT;
            state_nxt = ERR;
          end else begin
            cnt_nxt = cnt_q + 32'd1;
          end
        end
      end
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      reqv_q  <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
      reqv_q  <= reqv_nxt;
      wen_q   <= wen_nxt;
      wdata_q <= wdata_nxt;
      mask_q  <= mask_nxt;
      addr_q  <= addr_nxt;
      cnt_q   <= cnt_nxt;
      off_q   <= off_nxt;
      f3_q    <= f3_nxt;
    end
  end

  assign cpu_ready    = idle;
  assign cpu_done     = done_q;
  assign cpu_err      = err_q;
  assign cpu_rdata    = rdata_q;
  assign mem.reqValid = reqv_q;
  assign mem.wen      = wen_q;
  assign mem.wdata    = wdata_q;
  assign mem.wbmask   = mask_q;
  assign mem.addr     = addr_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: table of load/store vectors against a small word memory, plus timeout and reset corners.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_wen;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_err;

  always #5 clock = ~clock;

  lsu_mem_master_if #(.XLEN(32)) mem ();

  lsu_mem_master #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_wen    (cpu_wen),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .mem        (mem.master)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];
  logic [31:0] bmem [int];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] err, input logic [31:0] rdata,
                              input logic [3:0] mask, input logic [31:0] mwdata);
    vec_t v;
    v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.mask = mask; v.mwdata = mwdata;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t        v;
    logic [31:0] w;
    int          wa;
    v = vt[i];
    cpu_valid = 1'b1; cpu_wen = v.wen; cpu_funct3 = v.f3; cpu_addr = v.addr; cpu_wdata = v.wdata;
    tick();
    cpu_valid = 1'b0;
    if (v.err != 2'b00) begin
      chk($sformatf("v%0d_done", i), 32'(cpu_done), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(cpu_err), 32'(v.err));
      chk($sformatf("v%0d_rdata", i), cpu_rdata, 32'd0);
      chk($sformatf("v%0d_noreq", i), 32'(mem.reqValid), 32'd0);
      chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(cpu_done), 32'd0);
      chk($sformatf("v%0d_noreq2", i), 32'(mem.reqValid), 32'd0);
    end else begin
      chk($sformatf("v%0d_req", i), 32'(mem.reqValid), 32'd1);
      chk($sformatf("v%0d_addr", i), mem.addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_wen", i), 32'(mem.wen), 32'(v.wen));
      if (v.wen) begin
        chk($sformatf("v%0d_mask", i), 32'(mem.wbmask), 32'(v.mask));
        chk($sformatf("v%0d_mwdata", i), mem.wdata, v.mwdata);
      end
      tick();
      chk($sformatf("v%0d_req_pulse", i), 32'(mem.reqValid), 32'd0);
      chk($sformatf("v%0d_early_done", i), 32'(cpu_done), 32'd0);
      wa = int'(v.addr >> 2);
      w = bmem.exists(wa) ? bmem[wa] : 32'd0;
      mem.respValid = 1'b1;
      mem.rdata = w;
      if (v.wen) begin
        for (int b = 0; b < 4; b++)
          if (v.mask[b]) w[8*b +: 8] = v.mwdata[8*b +: 8];
        bmem[wa] = w;
      end
      tick();
      mem.respValid = 1'b0;
      mem.rdata = 32'h0;
      chk($sformatf("v%0d_done", i), 32'(cpu_done), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(cpu_err), 32'd0);
      chk($sformatf("v%0d_rdata", i), cpu_rdata, v.rdata);
      chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(cpu_done), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    chk({tag, "_done"}, 32'(cpu_done), 32'd0);
    chk({tag, "_err"}, 32'(cpu_err), 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_req"}, 32'(mem.reqValid), 32'd0);
    chk({tag, "_wen"}, 32'(mem.wen), 32'd0);
    chk({tag, "_mwdata"}, mem.wdata, 32'd0);
    chk({tag, "_mask"}, 32'(mem.wbmask), 32'd0);
    chk({tag, "_addr"}, mem.addr, 32'd0);
  endtask

  initial begin
    int n;
    int reqs;
    int readies;
    // wen, f3, addr, wdata, err, rdata, mask, mem wdata
    vt[0]  = mk(1'b1, F3_W,  32'h100, 32'hDEADBEEF, 2'b00, 32'h0,        4'b1111, 32'hDEADBEEF);
    vt[1]  = mk(1'b0, F3_W,  32'h100, 32'h0,        2'b00, 32'hDEADBEEF, 4'b0000, 32'h0);
    vt[2]  = mk(1'b1, F3_B,  32'h103, 32'h000000A5, 2'b00, 32'h0,        4'b1000, 32'hA5A5A5A5);
    vt[3]  = mk(1'b0, F3_B,  32'h103, 32'h0,        2'b00, 32'hFFFFFFA5, 4'b0000, 32'h0);
    vt[4]  = mk(1'b0, F3_BU, 32'h103, 32'h0,        2'b00, 32'h000000A5, 4'b0000, 32'h0);
    vt[5]  = mk(1'b1, F3_W,  32'h200, 32'h80017FFF, 2'b00, 32'h0,        4'b1111, 32'h80017FFF);
    vt[6]  = mk(1'b0, F3_H,  32'h202, 32'h0,        2'b00, 32'hFFFF8001, 4'b0000, 32'h0);
    vt[7]  = mk(1'b0, F3_HU, 32'h202, 32'h0,        2'b00, 32'h00008001, 4'b0000, 32'h0);
    vt[8]  = mk(1'b0, F3_H,  32'h200, 32'h0,        2'b00, 32'h00007FFF, 4'b0000, 32'h0);
    vt[9]  = mk(1'b1, F3_H,  32'h102, 32'hCAFE1234, 2'b00, 32'h0,        4'b1100, 32'h12341234);
    vt[10] = mk(1'b0, F3_W,  32'h100, 32'h0,        2'b00, 32'h1234BEEF, 4'b0000, 32'h0);
    vt[11] = mk(1'b0, F3_W,  32'h102, 32'h0,        2'b01, 32'h0,        4'b0000, 32'h0);
    vt[12] = mk(1'b0, F3_H,  32'h101, 32'h0,        2'b01, 32'h0,        4'b0000, 32'h0);
    vt[13] = mk(1'b0, 3'd3,  32'h100, 32'h0,        2'b11, 32'h0,        4'b0000, 32'h0);
    vt[14] = mk(1'b1, 3'd3,  32'h100, 32'h0,        2'b11, 32'h0,        4'b0000, 32'h0);
    vt[15] = mk(1'b0, F3_B,  32'h101, 32'h0,        2'b00, 32'hFFFFFFBE, 4'b0000, 32'h0);
    vt[16] = mk(1'b0, F3_W,  32'h100, 32'h0,        2'b00, 32'h1234BEEF, 4'b0000, 32'h0);

    cpu_valid = 1'b0; cpu_wen = 1'b0; cpu_funct3 = 3'd0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    mem.respValid = 1'b0; mem.rdata = 32'h0;

    #12;
    chk_reset_outputs("rst");
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV - 1; i++) run_vec(i);

    // No response: fatal timeout, then the unit stays parked.
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_funct3 = F3_W; cpu_addr = 32'h300;
    tick();
    cpu_valid = 1'b0;
    chk("to_req", 32'(mem.reqValid), 32'd1);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (cpu_done) begin
        n = k;
        break;
      end
    end
    chk("to_latency", 32'(n), 32'd9);
    chk("to_err", 32'(cpu_err), 32'(ERR_TIMEOUT));
    chk("to_rdata", cpu_rdata, 32'd0);
    reqs = 0; readies = 0;
    cpu_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem.reqValid) reqs++;
      if (cpu_ready) readies++;
    end
    cpu_valid = 1'b0;
    chk("err_no_req", 32'(reqs), 32'd0);
    chk("err_not_ready", 32'(readies), 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset asserted while waiting for a response.
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_funct3 = F3_W; cpu_addr = 32'h100;
    tick();
    cpu_valid = 1'b0;
    tick();
    chk("wait_reqlow", 32'(mem.reqValid), 32'd0);
    chk("wait_busy", 32'(cpu_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_wait");
    tick();
    reset = 1'b0;
    mem.respValid = 1'b1; mem.rdata = 32'h55AA55AA;
    tick();
    mem.respValid = 1'b0; mem.rdata = 32'h0;
    chk("stray_done0", 32'(cpu_done), 32'd0);
    tick();
    chk("stray_done1", 32'(cpu_done), 32'd0);
    run_vec(NV - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
